timer_count_unit: RTL and testbench
===================================

# timer_count_unit

Clocked counting stage of the 8-bit timer. It drives the `count` value consumed by the overflow/underflow comparison stage downstream. It takes the timer control register (TCR) and timer data register (TDR), and generates an internal prescaled count enable from PCLK. Each enabled tick moves the count up or down by one, wrapping around, and TDR can be loaded into the count at any time.

## Interface
- `WIDTH`, 8: counter and TDR width.
- `PSC_W`, 4: prescaler width; supports divide-by 2/4/8/16.

Ports:
- `PCLK`, input, 1: the single clock.
- `RST`, input, 1: reset, asynchronous, active-high.
- `TCR`, input, 8: timer control.
  - [7] load
  - [5] direction (0 up, 1 down)
  - [4] enable
  - [1:0] clock select
  - Other bits are ignored.
- `TDR`, input, WIDTH: load value.
- `count`, output, WIDTH: registered counter value, fed to the comparison stage.
- `cnt_tick`, output, 1: one-cycle pulse, high in the cycle `count` shows a value produced by a counting step.
- `cnt_dir`, output, 1: registered direction of the last counting step (0 up, 1 down).

## Operation
- Reset (async, immediate): `count`=0, `cnt_tick`=0, `cnt_dir`=0, prescaler=0.
- Mode priority is evaluated every PCLK edge:
  1. **LOAD** (TCR[7]=1):
     - `count` <= TDR on every edge while asserted.
     - Prescaler cleared to 0; `cnt_tick` <= 0; `cnt_dir` unchanged.
     - Load dominates enable.
  2. **IDLE** (TCR[7]=0, TCR[4]=0):
     - `count` holds; prescaler cleared to 0; `cnt_tick` <= 0.
  3. **RUN** (TCR[7]=0, TCR[4]=1):
     - Prescaler increments modulo 2^PSC_W.
     - Step enable `psc_hit` = prescaler bits [k:0] all ones, where k = TCR[1:0]: 00 → /2, 01 → /4, 10 → /8, 11 → /16.
     - When `psc_hit`: `count` <= `count`+1 (TCR[5]=0) or `count`−1 (TCR[5]=1), modulo 2^WIDTH. Also `cnt_tick` <= 1 and `cnt_dir` <= TCR[5].
     - Otherwise: `count` holds and `cnt_tick` <= 0.
- Wrap-around:
  - Up: FF → 00.
  - Down: 00 → FF.
  - No saturation and no stop. Flag generation belongs to the downstream stage.
- Changing TCR[1:0] in RUN: the prescaler is not cleared. The next step occurs at the first edge where the new mask condition holds.
- Changing TCR[5] in RUN: takes effect at the next step. No extra step is generated.
- TDR changes while not in LOAD: no effect on `count`.
- Releasing load (TCR[7] 1→0 with enable=1): the prescaler starts from 0. The first step comes 2^(k+1) edges after the first RUN edge.

## Timing
- All outputs are registered and have no combinational path from inputs.
- Load latency: 1 edge (TDR sampled at edge N, visible after edge N).
- Step period in steady RUN: exactly 2^(k+1) PCLK cycles between `cnt_tick` pulses.
- First step after entering RUN (from IDLE or LOAD): `count` changes on the 2^(k+1)-th edge with enable=1, counting the first such edge as 1.
- `cnt_tick` is high for exactly one cycle per step and is never high two cycles in a row, because the minimum divide is 2.
- Reset mid-run: outputs clear immediately. After RST deasserts, behaviour is as from power-up; the first step follows the first-step rule.

## Structure
- Shared package `timer_pkg` holds:
  - TCR bit indices: `TCR_LOAD`=7, `TCR_DIR`=5, `TCR_EN`=4, `TCR_CKS_LSB`=0.
  - Clock-select encodings `CKS_DIV2..CKS_DIV16`.
  - `DIR_UP`/`DIR_DOWN`.
  - These are shared with the comparison stage and the register block.
- Sub-module `timer_prescaler`:
  - Inputs: PCLK, RST, `clr`, `en`, `cks[1:0]`.
  - Output: `psc_hit`.
  - Contains the prescaler counter and mask decode.
- The top level holds the count register, the mode decode, `cnt_tick`, and `cnt_dir`.

## Test plan
- **Reset**: assert RST mid-count at `count`=0x37 → `count`=0, `cnt_tick`=0 immediately (before the next edge); after release with TCR=0x10, first step at the 2nd edge → `count`=0x01.
- **Load then count up /2**: TDR=0xFE, TCR=0x80 for 1 cycle → `count`=0xFE. Then TCR=0x10 → steps every 2 cycles: FE, FF, 00, 01, with `cnt_tick` pulses, `cnt_dir`=0, and wrap FF→00.
- **Count down /2**: load 0x01, then TCR=0x30 → sequence 01, 00, FF, FE with `cnt_dir`=1, and wrap 00→FF.
- **Prescaler**: TCR=0x13 from `count`=0 → `cnt_tick` every 16 cycles. Switch to 0x11 mid-period → next tick at the first edge where prescaler[1:0]=3, then every 4 cycles.
- **Priority**: TCR=0x90 with TDR=0x55 held 5 cycles → `count`=0x55 throughout, no `cnt_tick`. Clear TCR[7] → first step after 2 edges to 0x56.
- **Idle hold**: TCR=0x00 for 20 cycles at `count`=0xA0 → `count` stays 0xA0, `cnt_tick` stays 0; TDR changes have no effect.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared timer definitions: TCR field positions, clock-select codes, directions
// and the count-stage mode decode used by the counting, compare and register blocks.
package timer_pkg;

    localparam int unsigned TCR_LOAD    = 7;
    localparam int unsigned TCR_DIR     = 5;
    localparam int unsigned TCR_EN      = 4;
    localparam int unsigned TCR_CKS_LSB = 0;

    localparam logic [1:0] CKS_DIV2  = 2'b00;
    localparam logic [1:0] CKS_DIV4  = 2'b01;
    localparam logic [1:0] CKS_DIV8  = 2'b10;
    localparam logic [1:0] CKS_DIV16 = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        ModeIdle = 2'b00,
        ModeLoad = 2'b01,
        ModeRun  = 2'b10
    } mode_e;

    // Load dominates enable.
    function automatic mode_e tcr_mode(input logic load, input logic en);
        mode_e mode;
        if (load) begin
            mode = ModeLoad;
        end else if (en) begin
            mode = ModeRun;
        end else begin
            mode = ModeIdle;
        end
        return mode;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler for the timer count stage; psc_hit marks the edge on
// which the selected low prescaler bits are all ones.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned PSC_W = 4
) (
    input  logic       PCLK,
    input  logic       RST,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] cks,
    output logic       psc_hit
);

    logic [PSC_W-1:0] r_psc;
    logic [PSC_W-1:0] w_mask;

    always_comb begin
        w_mask = '0;
        unique case (cks)
            CKS_DIV2:  w_mask = PSC_W'(32'd1);
            CKS_DIV4:  w_mask = PSC_W'(32'd3);
            CKS_DIV8:  w_mask = PSC_W'(32'd7);
            CKS_DIV16: w_mask = PSC_W'(32'd15);
            default:   w_mask = '0;
        endcase
    end

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            r_psc <= '0;
        end else if (clr) begin
            r_psc <= '0;
        end else if (en) begin
            r_psc <= r_psc + 1'b1;
        end
    end

    // The mask compares the pre-increment value, so a cleared prescaler needs
    // 2^(k+1) enabled edges before the first hit.
    assign psc_hit = en & ~clr & ((r_psc & w_mask) == w_mask);

endmodule

// File: rtl/timer_count_unit.sv
// Clocked counting stage of the 8-bit timer: load/idle/run mode decode, the
// wrapping up/down count register, and the registered step pulse and direction.
module timer_count_unit
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PSC_W = 4
) (
    input  logic             PCLK,
    input  logic             RST,
    input  logic [7:0]       TCR,
    input  logic [WIDTH-1:0] TDR,
    output logic [WIDTH-1:0] count,
    output logic             cnt_tick,
    output logic             cnt_dir
);

    mode_e            w_mode;
    logic             w_psc_en;
    logic             w_psc_clr;
    logic             w_psc_hit;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             w_unused_tcr;

    assign w_mode       = tcr_mode(TCR[TCR_LOAD], TCR[TCR_EN]);
    assign w_psc_en     = (w_mode == ModeRun);
    assign w_psc_clr    = ~w_psc_en;
    assign w_unused_tcr = ^{TCR[6], TCR[3:2]};

    timer_prescaler #(
        .PSC_W (PSC_W)
    ) u_prescaler (
        .PCLK    (PCLK),
        .RST     (RST),
        .clr     (w_psc_clr),
        .en      (w_psc_en),
        .cks     (TCR[TCR_CKS_LSB +: 2]),
        .psc_hit (w_psc_hit)
    );

    always_comb begin
        w_count_nxt = r_count;
        w_tick_nxt  = 1'b0;
        w_dir_nxt   = r_dir;
        unique case (w_mode)
            ModeLoad: begin
                w_count_nxt = TDR;
            end
            ModeRun: begin
                if (w_psc_hit) begin
                    w_tick_nxt = 1'b1;
                    w_dir_nxt  = TCR[TCR_DIR];
                    if (TCR[TCR_DIR] == DIR_DOWN) begin
                        w_count_nxt = r_count - 1'b1;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
            r_tick  <= 1'b0;
            r_dir   <= DIR_UP;
        end else begin
            r_count <= w_count_nxt;
            r_tick  <= w_tick_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    assign count    = r_count;
    assign cnt_tick = r_tick;
    assign cnt_dir  = r_dir;

    // Minimum divide is 2, so a step pulse can never repeat on the next edge.
    a_tick_not_back_to_back : assert property (
        @(posedge PCLK) disable iff (RST) cnt_tick |=> !cnt_tick
    );

endmodule

// File: tb/tb_timer_count_unit.sv
// Bench for timer_count_unit: directed scenarios with literal expectations plus
// randomized TCR/TDR/RST traffic, all checked every cycle against a reference model.
module tb_timer_count_unit;

    logic       PCLK = 1'b0;
    logic       RST;
    logic [7:0] TCR;
    logic [7:0] TDR;
    logic [7:0] count;
    logic       cnt_tick;
    logic       cnt_dir;

    int   n_err    = 0;
    int   n_checks = 0;
    logic chk_en   = 1'b0;

    // Reference model state
    int   m_count;
    int   m_psc;
    logic m_tick;
    logic m_dir;

    timer_count_unit #(
        .WIDTH (8),
        .PSC_W (4)
    ) dut (
        .PCLK     (PCLK),
        .RST      (RST),
        .TCR      (TCR),
        .TDR      (TDR),
        .count    (count),
        .cnt_tick (cnt_tick),
        .cnt_dir  (cnt_dir)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 2 time units before touching inputs.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #2;
        end
    endtask

    // Model: step when the prescaler value sits on the last slot of its period.
    always @(posedge PCLK or posedge RST) begin : model
        int per;
        if (RST) begin
            m_count <= 0;
            m_psc   <= 0;
            m_tick  <= 1'b0;
            m_dir   <= 1'b0;
        end else if (TCR[7]) begin
            m_count <= int'(TDR);
            m_psc   <= 0;
            m_tick  <= 1'b0;
        end else if (!TCR[4]) begin
            m_psc   <= 0;
            m_tick  <= 1'b0;
        end else begin
            per   = 2 << TCR[1:0];
            m_psc <= (m_psc + 1) % 16;
            if ((m_psc % per) == per - 1) begin
                m_count <= TCR[5] ? (m_count + 255) % 256 : (m_count + 1) % 256;
                m_tick  <= 1'b1;
                m_dir   <= TCR[5];
            end else begin
                m_tick  <= 1'b0;
            end
        end
    end

    always @(negedge PCLK) begin
        if (chk_en) begin
            chk("model_count", 32'(count), 32'(m_count));
            chk("model_tick", 32'(cnt_tick), 32'(m_tick));
            chk("model_dir", 32'(cnt_dir), 32'(m_dir));
        end
    end

    initial begin
        logic [7:0] tcr_v;
        RST = 1'b1;
        TCR = 8'h00;
        TDR = 8'h00;
        cyc(2);
        RST = 1'b0;
        chk_en = 1'b1;
        chk("reset_count", 32'(count), 32'h00);
        chk("reset_tick", 32'(cnt_tick), 32'h0);
        chk("reset_dir", 32'(cnt_dir), 32'h0);

        // Reset mid-count at 0x37
        TDR = 8'h37; TCR = 8'h80; cyc(1);
        chk("load_37", 32'(count), 32'h37);
        TCR = 8'h10; cyc(1);
        RST = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 32'h00);
        chk("async_rst_tick", 32'(cnt_tick), 32'h0);
        cyc(1);
        RST = 1'b0;
        cyc(1);
        chk("post_rst_edge1", 32'(count), 32'h00);
        cyc(1);
        chk("post_rst_edge2", 32'(count), 32'h01);
        chk("post_rst_tick", 32'(cnt_tick), 32'h1);

        // Load 0xFE then count up /2 through the FF->00 wrap
        TDR = 8'hFE; TCR = 8'h80; cyc(1);
        chk("load_fe", 32'(count), 32'hFE);
        TCR = 8'h10;
        cyc(2); chk("up_ff", 32'(count), 32'hFF); chk("up_tick", 32'(cnt_tick), 32'h1);
        cyc(2); chk("up_wrap_00", 32'(count), 32'h00); chk("up_dir", 32'(cnt_dir), 32'h0);
        cyc(2); chk("up_01", 32'(count), 32'h01);

        // Load 0x01 then count down /2 through the 00->FF wrap
        TDR = 8'h01; TCR = 8'h80; cyc(1);
        chk("load_01", 32'(count), 32'h01);
        TCR = 8'h30;
        cyc(2); chk("dn_00", 32'(count), 32'h00); chk("dn_dir", 32'(cnt_dir), 32'h1);
        cyc(2); chk("dn_wrap_ff", 32'(count), 32'hFF);
        cyc(2); chk("dn_fe", 32'(count), 32'hFE);

        // Prescaler /16, then switch to /4 mid-period
        TDR = 8'h00; TCR = 8'h80; cyc(1);
        TCR = 8'h13;
        cyc(15); chk("div16_wait", 32'(count), 32'h00); chk("div16_notick", 32'(cnt_tick), 32'h0);
        cyc(1);  chk("div16_step1", 32'(count), 32'h01); chk("div16_tick", 32'(cnt_tick), 32'h1);
        cyc(16); chk("div16_step2", 32'(count), 32'h02);
        cyc(5);
        TCR = 8'h11;
        cyc(2); chk("div4_wait", 32'(cnt_tick), 32'h0);
        cyc(1); chk("div4_first", 32'(count), 32'h03); chk("div4_first_tick", 32'(cnt_tick), 32'h1);
        cyc(3); chk("div4_gap", 32'(cnt_tick), 32'h0);
        cyc(1); chk("div4_second", 32'(count), 32'h04);

        // Load dominates enable
        TDR = 8'h55; TCR = 8'h90;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("prio_count", 32'(count), 32'h55);
            chk("prio_tick", 32'(cnt_tick), 32'h0);
        end
        TCR = 8'h10;
        cyc(1); chk("prio_rel1", 32'(count), 32'h55);
        cyc(1); chk("prio_rel2", 32'(count), 32'h56);

        // Idle hold, TDR wiggling
        TDR = 8'hA0; TCR = 8'h80; cyc(1);
        TCR = 8'h00;
        for (int i = 0; i < 20; i++) begin
            TDR = 8'($urandom);
            cyc(1);
        end
        chk("idle_count", 32'(count), 32'hA0);
        chk("idle_tick", 32'(cnt_tick), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            tcr_v    = 8'($urandom);
            tcr_v[7] = ($urandom_range(0, 9) == 0);
            tcr_v[4] = ($urandom_range(0, 3) != 0);
            TCR = tcr_v;
            TDR = 8'($urandom);
            RST = ($urandom_range(0, 49) == 0);
            cyc($urandom_range(1, 20));
        end
        RST = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
